universal_shift_register: RTL and testbench

Parametrised successor to the team's 4-bit load/shift register. It holds a WIDTH-bit word and executes one command at a time: hold, load, clear, logical shift right or left, rotate right or left, and arithmetic shift right. Each shift command moves the word by a commanded amount, one bit per clock. A start/busy/done handshake sequences the commands. The block serves as a reusable datapath register and serial converter in lab designs.

---
 rtl/usr_pkg.sv | 92 +++++++++
 rtl/usr_sequencer.sv | 82 ++++++++
 rtl/universal_shift_register.sv | 94 +++++++++
 tb/tb_universal_shift_register.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types and the combinational step function for the universal shift register.
package usr_pkg;

  // Widest register the step function handles; narrower words are zero-extended.
  localparam int unsigned USR_MAX_W = 64;

  typedef logic [USR_MAX_W-1:0] usr_word_t;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHR   = 3'b010,
    OP_SHL   = 3'b011,
    OP_ROR   = 3'b100,
    OP_ROL   = 3'b101,
    OP_ASR   = 3'b110,
    OP_CLEAR = 3'b111
  } usr_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Result of one step: next word, the bit that left it, and whether ser_out changes.
  typedef struct packed {
    usr_word_t q;
    logic      ser;
    logic      ser_upd;
  } usr_step_t;

  // Commands that move the word and therefore take a per-step amount.
  function automatic logic usr_is_shift(input usr_op_e op);
    return op inside {OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR};
  endfunction

  // One step of the datapath on a width-bit word held in the low bits of q.
  // HOLD and LOAD return q untouched; the caller supplies the load data.
  function automatic usr_step_t usr_step(input usr_word_t   q,
                                         input int unsigned width,
                                         input usr_op_e     op,
                                         input logic        shr_in,
                                         input logic        shl_in);
    usr_step_t res;
    usr_word_t mask;
    usr_word_t top;
    logic      msb;
    logic      lsb;
    mask = (width >= USR_MAX_W) ? '1 : ((usr_word_t'(1) << width) - usr_word_t'(1));
    top  = mask ^ (mask >> 1);  // one-hot at the MSB position of the live word
    msb  = |(q & top);
    lsb  = q[0];
    res.q       = q;
    res.ser     = 1'b0;
    res.ser_upd = 1'b0;
    case (op)
      OP_SHR: begin
        res.q       = ((q >> 1) & ~top) | (shr_in ? top : '0);
        res.ser     = lsb;
        res.ser_upd = 1'b1;
      end
      OP_SHL: begin
        res.q       = ((q << 1) | usr_word_t'(shl_in)) & mask;
        res.ser     = msb;
        res.ser_upd = 1'b1;
      end
      OP_ROR: begin
        res.q       = ((q >> 1) & ~top) | (lsb ? top : '0);
        res.ser     = lsb;
        res.ser_upd = 1'b1;
      end
      OP_ROL: begin
        res.q       = ((q << 1) | usr_word_t'(msb)) & mask;
        res.ser     = msb;
        res.ser_upd = 1'b1;
      end
      OP_ASR: begin
        res.q       = ((q >> 1) & ~top) | (msb ? top : '0);
        res.ser     = lsb;
        res.ser_upd = 1'b1;
      end
      OP_CLEAR: begin
        res.q       = '0;
        res.ser     = 1'b0;
        res.ser_upd = 1'b1;
      end
      default: ;  // HOLD, LOAD
    endcase
    return res;
  endfunction

endpackage

// File: rtl/usr_sequencer.sv
// Command sequencer: start/busy/done handshake, amount clamp and step counter.
module usr_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  usr_op_e          op_i,
  input  logic [CNT_W-1:0] amt_i,
  output logic             accept_o,
  output logic             step_en_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] steps;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign accept_o  = start_i && (state_q == IDLE);
  assign step_en_o = (state_q == RUN);
  assign busy_o    = busy_q;
  assign done_o    = done_q;

  // Number of steps for the requested command: clamped amount, or one.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    steps = ONE;
    if (usr_is_shift(op_i) && (amt_i != '0)) begin
      steps = (amt_i > W_CNT) ? W_CNT : amt_i;
    end
  end

  // Next-state logic: accept in IDLE, count down in RUN, pulse done on the last step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          cnt_d   = steps;
        end
      end
      RUN: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  // FSM and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: WIDTH-bit word with load/clear/shift/rotate commands,
// one bit per clock, sequenced by a start/busy/done handshake.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amt,
  input  logic             start,
  input  logic             shr_in,
  input  logic             shl_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             ser_out
);

  usr_op_e          op_in;
  usr_op_e          op_q, op_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_q, ser_d;
  logic             accept;
  logic             step_en;
  usr_step_t        step_res;
  logic             unused_hi;

  assign op_in = usr_op_e'(op);

  usr_sequencer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start),
    .op_i      (op_in),
    .amt_i     (amt),
    .accept_o  (accept),
    .step_en_o (step_en),
    .busy_o    (busy),
    .done_o    (done)
  );

  assign step_res  = usr_step(usr_word_t'(q_q), WIDTH, op_q, shr_in, shl_in);
  // Bits above WIDTH are always zero; fold them so nothing is left dangling.
  assign unused_hi = ^(step_res.q >> WIDTH);

  // Capture the command on acceptance; a zero-amount shift becomes a single HOLD step.
  always_comb begin
    op_d = op_q;
    d_d  = d_q;
    if (accept) begin
      op_d = (usr_is_shift(op_in) && (amt == '0)) ? OP_HOLD : op_in;
      d_d  = d;
    end
  end

  // Datapath: apply one step of the captured command whenever the sequencer enables it.
  always_comb begin
    q_d   = q_q;
    ser_d = ser_q;
    if (step_en) begin
      q_d = (op_q == OP_LOAD) ? d_q : step_res.q[WIDTH-1:0];
      if (step_res.ser_upd) begin
        ser_d = step_res.ser;
      end
    end
  end

  // Word, serial-out and captured-command registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q   <= '0;
      ser_q <= 1'b0;
      op_q  <= OP_HOLD;
      d_q   <= '0;
    end else begin
      q_q   <= q_d;
      ser_q <= ser_d;
      op_q  <= op_d;
      d_q   <= d_d;
    end
  end

  assign q       = q_q;
  assign ser_out = ser_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=8): directed commands,
// a transaction-level reference model compared every cycle, plus literal spot checks.
module tb_universal_shift_register;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHR = 3'd2, SHL = 3'd3;
  localparam logic [2:0] ROR  = 3'd4, ROL  = 3'd5, ASR = 3'd6, CLR = 3'd7;

  logic             clk    = 1'b0;
  logic             reset  = 1'b0;
  logic [WIDTH-1:0] d      = '0;
  logic [2:0]       op     = '0;
  logic [CNT_W-1:0] amt    = '0;
  logic             start  = 1'b0;
  logic             shr_in = 1'b0;
  logic             shl_in = 1'b0;
  logic [WIDTH-1:0] q;
  logic             busy, done, ser_out;

  int checks = 0;
  int passed = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  universal_shift_register #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .d       (d),
    .op      (op),
    .amt     (amt),
    .start   (start),
    .shr_in  (shr_in),
    .shl_in  (shl_in),
    .q       (q),
    .busy    (busy),
    .done    (done),
    .ser_out (ser_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a command is "remaining steps of an op"; each step is plain
  // integer arithmetic on an 8-bit value.
  int m_q = 0, m_ser = 0, m_busy = 0, m_done = 0, m_left = 0, m_op = 0, m_d = 0;

  always @(posedge clk) begin : model
    int nq, nser, nbusy, ndone, nleft, nop, nd, a;
    nq = m_q; nser = m_ser; nbusy = m_busy; ndone = m_done;
    nleft = m_left; nop = m_op; nd = m_d;
    if (!reset) begin
      nq = 0; nser = 0; nbusy = 0; ndone = 0; nleft = 0;
    end else begin
      ndone = 0;
      if (m_busy != 0) begin
        case (m_op)
          LOAD: nq = m_d;
          CLR:  begin nq = 0; nser = 0; end
          SHR:  begin nser = m_q % 2; nq = m_q / 2 + (shr_in ? 128 : 0); end
          SHL:  begin nser = m_q / 128; nq = (m_q * 2) % 256 + int'(shl_in); end
          ROR:  begin nser = m_q % 2; nq = m_q / 2 + nser * 128; end
          ROL:  begin nser = m_q / 128; nq = (m_q * 2) % 256 + nser; end
          ASR:  begin nser = m_q % 2; nq = m_q / 2 + ((m_q >= 128) ? 128 : 0); end
          default: ;
        endcase
        nleft = m_left - 1;
        if (nleft == 0) begin
          nbusy = 0;
          ndone = 1;
        end
      end else if (start) begin
        nbusy = 1;
        nop   = int'(op);
        nd    = int'(d);
        a     = int'(amt);
        nleft = 1;
        if (op inside {SHR, SHL, ROR, ROL, ASR}) begin
          if (a == 0) nop = HOLD;
          else nleft = (a > WIDTH) ? WIDTH : a;
        end
      end
    end
    m_q    <= nq;
    m_ser  <= nser;
    m_busy <= nbusy;
    m_done <= ndone;
    m_left <= nleft;
    m_op   <= nop;
    m_d    <= nd;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_q",    q,       m_q);
      check("model_busy", busy,    m_busy);
      check("model_done", done,    m_done);
      check("model_ser",  ser_out, m_ser);
    end
  end

  // Present a command for one edge; returns at the negedge after acceptance.
  task automatic issue(input logic [2:0] o, input logic [CNT_W-1:0] a, input logic [7:0] dd);
    op = o; amt = a; d = dd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_done;
    // Reset held for two edges while a LOAD is requested.
    reset = 1'b0; start = 1'b1; op = LOAD; d = 8'hFF;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_q",    q,       8'h00);
    check("rst_busy", busy,    1'b0);
    check("rst_done", done,    1'b0);
    check("rst_ser",  ser_out, 1'b0);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);

    // LOAD A5: one step, busy one cycle, done one cycle.
    issue(LOAD, 0, 8'hA5);
    check("load_busy_e0", busy, 1'b1);
    @(negedge clk);
    check("load_q",       q,    8'hA5);
    check("load_done",    done, 1'b1);
    check("load_busy_e1", busy, 1'b0);
    @(negedge clk);
    check("load_done_end", done, 1'b0);

    // SHR by 3 with shr_in=1.
    shr_in = 1'b1;
    issue(SHR, 3, 8'h00);
    @(negedge clk);
    check("shr_q1", q, 8'hD2); check("shr_s1", ser_out, 1'b1);
    @(negedge clk);
    check("shr_q2", q, 8'hE9); check("shr_s2", ser_out, 1'b0);
    @(negedge clk);
    check("shr_q3", q, 8'hF4); check("shr_s3", ser_out, 1'b1);
    check("shr_done", done, 1'b1);
    @(negedge clk);

    // ROL by 12 clamps to 8 steps.
    issue(LOAD, 0, 8'h81);
    repeat (2) @(negedge clk);
    issue(ROL, 12, 8'h00);
    repeat (7) @(negedge clk);
    check("rol_q7",    q,    8'hC0);
    check("rol_busy7", busy, 1'b1);
    @(negedge clk);
    check("rol_q8",    q,    8'h81);
    check("rol_done8", done, 1'b1);
    @(negedge clk);

    // ASR by 2 from 90.
    issue(LOAD, 0, 8'h90);
    repeat (2) @(negedge clk);
    issue(ASR, 2, 8'h00);
    repeat (2) @(negedge clk);
    check("asr_q",    q,       8'hE4);
    check("asr_ser",  ser_out, 1'b0);
    check("asr_done", done,    1'b1);
    @(negedge clk);

    // SHL with amt=0 is a single HOLD step, even with shl_in high.
    shl_in = 1'b1;
    issue(SHL, 0, 8'h00);
    @(negedge clk);
    check("shl0_q",    q,       8'hE4);
    check("shl0_ser",  ser_out, 1'b0);
    check("shl0_done", done,    1'b1);
    @(negedge clk);

    // Start while busy is ignored.
    shr_in = 1'b0;
    issue(LOAD, 0, 8'h0F);
    repeat (2) @(negedge clk);
    issue(SHR, 2, 8'h00);
    op = LOAD; d = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_q1", q, 8'h07);
    @(negedge clk);
    check("ign_q2", q, 8'h03); check("ign_ser", ser_out, 1'b1);
    check("ign_done", done, 1'b1);
    repeat (2) @(negedge clk);
    check("ign_q_after",    q,    8'h03);
    check("ign_busy_after", busy, 1'b0);

    // CLEAR zeroes both the word and ser_out.
    issue(CLR, 5, 8'h00);
    @(negedge clk);
    check("clr_q",   q,       8'h00);
    check("clr_ser", ser_out, 1'b0);
    @(negedge clk);

    // Reset at E2 of a 5-step SHR aborts with no done pulse.
    issue(LOAD, 0, 8'hF0);
    repeat (2) @(negedge clk);
    issue(SHR, 5, 8'h00);
    @(negedge clk);
    check("abort_q1", q, 8'h78);
    reset = 1'b0;
    @(negedge clk);
    check("abort_q",    q,    8'h00);
    check("abort_busy", busy, 1'b0);
    reset = 1'b1;
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    // Start during the done cycle is accepted.
    issue(LOAD, 0, 8'h3C);
    @(negedge clk);
    check("b2b_done", done, 1'b1);
    issue(ROR, 1, 8'h00);
    check("b2b_busy", busy, 1'b1);
    @(negedge clk);
    check("b2b_q",    q,       8'h1E);
    check("b2b_ser",  ser_out, 1'b0);
    check("b2b_fin",  done,    1'b1);
    repeat (2) @(negedge clk);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
